bsg_blackparrot_mc_fwd_credit_limiter: RTL

Bounds the number of outstanding manycore requests a BlackParrot tile can inject on one manycore link. It sits on the BP clock side, between one tile manycore link port and the fwd/rev async CDC pair feeding the horizontal IO router column. Each forward request consumes a credit and each returned reverse packet restores one. A fence input drains the link to zero outstanding requests.

---
 rtl/bsg_blackparrot_mc_fwd_credit_limiter.sv | 72 +++++++
 1 files changed

// File: rtl/bsg_blackparrot_mc_fwd_credit_limiter.sv
// bsg_blackparrot_mc_fwd_credit_limiter: caps outstanding manycore requests on one link, with fence drain
module bsg_blackparrot_mc_fwd_credit_limiter #(
  parameter int fwd_width_p = 32,
  parameter int rev_width_p = 32,
  parameter int max_out_p = 16,
  localparam int credit_width_lp = $clog2(max_out_p+1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       fwd_v_i,
  input  logic [fwd_width_p-1:0]     fwd_data_i,
  output logic                       fwd_ready_and_o,
  output logic                       fwd_v_o,
  output logic [fwd_width_p-1:0]     fwd_data_o,
  input  logic                       fwd_ready_and_i,
  input  logic                       rev_v_i,
  input  logic [rev_width_p-1:0]     rev_data_i,
  output logic                       rev_ready_and_o,
  output logic                       rev_v_o,
  output logic [rev_width_p-1:0]     rev_data_o,
  input  logic                       rev_ready_and_i,
  input  logic                       fence_i,
  output logic                       fence_done_o,
  output logic [credit_width_lp-1:0] credits_used_o,
  output logic                       error_o
);
  logic [1:0] n_q, n_d;
  logic [fwd_width_p-1:0] head_q, head_d, tail_q, tail_d;
  logic [credit_width_lp-1:0] count_q, count_d;
  logic error_q, error_d;
  logic full, empty, enq, deq, dec;
  assign full  = n_q == 2'd2;
  assign empty = n_q == 2'd0;
  assign fwd_ready_and_o = ~reset_i & ~fence_i & ~full & (count_q != credit_width_lp'(max_out_p));
  assign enq = fwd_v_i & fwd_ready_and_o;
  assign deq = ~empty & fwd_ready_and_i;
  assign dec = rev_v_i & rev_ready_and_i;
  assign fwd_v_o = ~empty;
  assign fwd_data_o = head_q;
  assign rev_ready_and_o = rev_ready_and_i;
  assign rev_v_o = rev_v_i;
  assign rev_data_o = rev_data_i;
  assign fence_done_o = ~reset_i & fence_i & (count_q == '0) & empty;
  assign credits_used_o = count_q;
  assign error_o = error_q;
  // Two-entry FIFO steering plus credit counter next state; enq and dec together cancel out
  always_comb begin
    n_d = n_q + 2'(enq) - 2'(deq);
    head_d = deq ? (full ? tail_q : fwd_data_i) : (empty ? fwd_data_i : head_q);
    tail_d = (enq & (n_q == 2'd1) & ~deq) ? fwd_data_i : tail_q;
    count_d = (enq & ~dec) ? count_q + credit_width_lp'(1)
            : (dec & ~enq & (count_q != '0)) ? count_q - credit_width_lp'(1) : count_q;
    error_d = error_q | (dec & ~enq & (count_q == '0));
  end
  // Control state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      n_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      n_q <= n_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end
  // Payload storage needs no reset; validity comes from n_q
  always_ff @(posedge clk_i) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end
endmodule
